// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - paced ADC conversion handshake with power-of-two averaging and timeout
// Optional per-dropped-tick overrun counter port: define ADC_SAMPLER_OVERRUN_EN.
module adc_sampler #(
  parameter int DATA_W       = 12,
  parameter int CLK_DIV      = 50000,
  parameter int AVG_LOG2     = 2,
  parameter int CONV_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_convst,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
`ifdef ADC_SAMPLER_OVERRUN_EN
  output logic [7:0]        overrun_cnt,
`endif
  output logic              timeout_err
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(CONV_TIMEOUT + 1);
  localparam int NAVG  = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT_HI,
    WAIT_LO,
    CAPTURE,
    EMIT
  } state_t;

  logic              busy_meta_q, busy_s_q;
  logic [DATA_W-1:0] data_meta_q, data_s_q;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              cs_q, cs_d;
  logic              convst_q, convst_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;
  logic [ACC_W-1:0]  sum;
  logic              tick;

  // The data bus is only sampled after busy_s has fallen, by which point it has long been stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      data_meta_q <= '0;
      data_s_q    <= '0;
    end else begin
      busy_meta_q <= adc_busy;
      busy_s_q    <= busy_meta_q;
      data_meta_q <= adc_data;
      data_s_q    <= data_meta_q;
    end
  end

  assign tick = enable && (div_q == DIV_W'(CLK_DIV - 1));
  assign sum  = acc_q + ACC_W'(data_s_q);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    cs_d     = cs_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    terr_d   = terr_q;

    if (!enable || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!enable) begin
          acc_d = '0;
          cnt_d = '0;
        end
        if (tick) begin
          state_d = CONVST;
          cs_d    = 1'b0;
        end
      end
      CONVST: begin
        if (cs_q) begin
          state_d = WAIT_HI;
          to_d    = '0;
        end else begin
          cs_d = 1'b1;
        end
      end
      WAIT_HI: begin
        if (busy_s_q) begin
          state_d = WAIT_LO;
          to_d    = '0;
        end else if (to_q == TO_W'(CONV_TIMEOUT)) begin
          state_d = IDLE;
          terr_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!busy_s_q) begin
          state_d = CAPTURE;
        end else if (to_q == TO_W'(CONV_TIMEOUT)) begin
          state_d = IDLE;
          terr_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      CAPTURE: begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
        // Load the output here so it is already valid during the EMIT strobe cycle.
        if (cnt_q == CNT_W'(NAVG - 1)) begin
          state_d  = EMIT;
          sample_d = sum[ACC_W-1:AVG_LOG2];
          valid_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    convst_d = (state_d == CONVST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      cs_q     <= 1'b0;
      convst_q <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      cs_q     <= cs_d;
      convst_q <= convst_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  assign adc_convst   = convst_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign timeout_err  = terr_q;

`ifdef ADC_SAMPLER_OVERRUN_EN
  logic [7:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (tick && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q <= 8'd0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - directed vectors and corner sequences for adc_sampler
// Overrun checks are compiled in when ADC_SAMPLER_OVERRUN_EN is defined.
module tb_adc_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_busy = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        adc_convst;
  logic [11:0] sample;
  logic        sample_valid;
  logic        timeout_err;

  logic        enable0 = 1'b0;
  logic        busy0 = 1'b0;
  logic [11:0] data0 = 12'd0;
  logic        convst0;
  logic [11:0] sample0;
  logic        valid0;
  logic        terr0;

`ifdef ADC_SAMPLER_OVERRUN_EN
  logic [7:0]  ovc_main, ovc0, ov_cnt;
  logic        enable_ov = 1'b0;
  logic        ov_busy = 1'b1;
  logic [11:0] ov_data = 12'd0;
  logic        ov_convst, ov_valid, ov_terr;
  logic [11:0] ov_sample;
`endif

  always #5 clk = ~clk;

  adc_sampler #(.DATA_W(12), .CLK_DIV(32), .AVG_LOG2(2), .CONV_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_busy(adc_busy), .adc_data(adc_data),
    .adc_convst(adc_convst), .sample(sample), .sample_valid(sample_valid),
`ifdef ADC_SAMPLER_OVERRUN_EN
    .overrun_cnt(ovc_main),
`endif
    .timeout_err(timeout_err)
  );

  adc_sampler #(.DATA_W(12), .CLK_DIV(16), .AVG_LOG2(0), .CONV_TIMEOUT(255)) dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .adc_busy(busy0), .adc_data(data0),
    .adc_convst(convst0), .sample(sample0), .sample_valid(valid0),
`ifdef ADC_SAMPLER_OVERRUN_EN
    .overrun_cnt(ovc0),
`endif
    .timeout_err(terr0)
  );

`ifdef ADC_SAMPLER_OVERRUN_EN
  adc_sampler #(.DATA_W(12), .CLK_DIV(16), .AVG_LOG2(2), .CONV_TIMEOUT(100000)) dut_ov (
    .clk(clk), .reset(reset), .enable(enable_ov), .adc_busy(ov_busy), .adc_data(ov_data),
    .adc_convst(ov_convst), .sample(ov_sample), .sample_valid(ov_valid),
    .overrun_cnt(ov_cnt), .timeout_err(ov_terr)
  );
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0, conv_cnt = 0, valid0_cnt = 0, conv0_cnt = 0;
  int conv_t[$];
  logic cs_prev = 1'b0, cs0_prev = 1'b0;
  int grp[4];
  int grp_base = 0;
  logic busy_mode = 1'b0;
  logic [11:0] d0 = 12'd0;

  typedef struct {
    int d0;
    int d1;
    int d2;
    int d3;
    int exp;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample_valid) valid_cnt++;
    if (adc_convst && !cs_prev) begin
      conv_cnt++;
      conv_t.push_back(cyc);
    end
    cs_prev = adc_convst;
    if (valid0) valid0_cnt++;
    if (convst0 && !cs0_prev) conv0_cnt++;
    cs0_prev = convst0;
  end

  // ADC model: busy rises 3 cycles after convst and stays high 5 cycles.
  always begin
    @(posedge adc_convst);
    repeat (3) @(posedge clk);
    #1;
    if (!busy_mode) begin
      adc_data = 12'(grp[(conv_cnt - grp_base - 1) & 3]);
      adc_busy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      adc_busy = 1'b0;
    end
  end

  always begin
    @(posedge convst0);
    repeat (2) @(posedge clk);
    #1;
    data0 = d0;
    busy0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    busy0 = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int start, input int budget, input string nm);
    int n = 0;
    while (valid_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(valid_cnt != start), 1);
  endtask

  task automatic wait_conv(input int target, input int budget, input string nm);
    int n = 0;
    while (conv_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(conv_cnt >= target), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_grp(input int a, input int b, input int c, input int d);
    grp[0] = a;
    grp[1] = b;
    grp[2] = c;
    grp[3] = d;
    grp_base = conv_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int vs, cb, cc, t, n;

    vecs[0] = '{d0: 100,  d1: 200,  d2: 300,  d3: 401,  exp: 250};
    vecs[1] = '{d0: 4095, d1: 4095, d2: 4095, d3: 4095, exp: 4095};
    vecs[2] = '{d0: 0,    d1: 0,    d2: 0,    d3: 3,    exp: 0};
    vecs[3] = '{d0: 1,    d1: 2,    d2: 3,    d3: 6,    exp: 3};
    vecs[4] = '{d0: 4095, d1: 4095, d2: 4095, d3: 4094, exp: 4094};

    repeat (3) @(negedge clk);
    chk("rst_convst", adc_convst, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_sample0", sample0, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      pulse_reset();
      load_grp(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      cb = conv_t.size();
      vs = valid_cnt;
      enable = 1'b1;
      wait_valid(vs, 4 * 32 + 40, $sformatf("vec%0d_valid_seen", i));
      enable = 1'b0;
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d_valid_count", i), valid_cnt - vs, 1);
      chk($sformatf("vec%0d_sample", i), sample, vecs[i].exp);
      if (i == 0) begin
        for (int k = 0; k < 3; k++)
          chk($sformatf("spacing%0d", k), conv_t[cb + k + 1] - conv_t[cb + k], 32);
      end
    end

    // Reset in the middle of WAIT_LO; sample still holds 4094 from the last vector.
    load_grp(40, 80, 120, 160);
    t = conv_cnt + 1;
    enable = 1'b1;
    wait_conv(t, 60, "mid_rst_conv_seen");
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_convst", adc_convst, 0);
    chk("mid_rst_sample", sample, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_terr", timeout_err, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    grp_base = conv_cnt;
    vs = valid_cnt;
    repeat (3 * 32 + 20) @(negedge clk);
    chk("mid_rst_no_early_valid", valid_cnt - vs, 0);
    wait_valid(vs, 80, "mid_rst_valid_seen");
    chk("mid_rst_new_sample", sample, 100);
    enable = 1'b0;
    repeat (40) @(negedge clk);

    // Timeout: two good conversions, one stuck, then a clean group of 1000s.
    pulse_reset();
    load_grp(4000, 4000, 4000, 4000);
    busy_mode = 1'b0;
    vs = valid_cnt;
    t = conv_cnt + 2;
    enable = 1'b1;
    wait_conv(t, 2 * 32 + 40, "to_two_convs");
    repeat (20) @(negedge clk);
    busy_mode = 1'b1;
    t = conv_cnt + 1;
    wait_conv(t, 40, "to_conv3_seen");
    repeat (15) @(negedge clk);
    chk("to_err_early", timeout_err, 0);
    repeat (15) @(negedge clk);
    chk("to_err_set", timeout_err, 1);
    load_grp(1000, 1000, 1000, 1000);
    busy_mode = 1'b0;
    wait_valid(vs, 4 * 32 + 40, "to_valid_seen");
    chk("to_valid_count", valid_cnt - vs, 1);
    chk("to_sample", sample, 1000);
    chk("to_err_sticky", timeout_err, 1);
    enable = 1'b0;
    repeat (40) @(negedge clk);

    // Enable dropped during WAIT_LO of the fourth conversion.
    pulse_reset();
    load_grp(10, 20, 30, 40);
    vs = valid_cnt;
    t = conv_cnt + 4;
    enable = 1'b1;
    wait_conv(t, 4 * 32 + 40, "en_fourth_conv");
    repeat (8) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_valid(vs, 30, "en_emit_seen");
    chk("en_sample", sample, 25);
    cc = conv_cnt;
    repeat (100) @(negedge clk);
    chk("en_no_convst", conv_cnt - cc, 0);
    chk("en_valid_count", valid_cnt - vs, 1);
    @(posedge clk);
    #1;
    enable = 1'b1;
    n = 0;
    while (!adc_convst && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("en_reenable_latency", n, 32);
    enable = 1'b0;
    repeat (40) @(negedge clk);

    // AVG_LOG2=0 instance: every conversion is emitted as-is.
    d0 = 12'h0A5;
    enable0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vs = valid0_cnt;
      n = 0;
      while (valid0_cnt == vs && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("avg0_valid%0d_seen", k), int'(valid0_cnt != vs), 1);
      chk($sformatf("avg0_sample%0d", k), sample0, (k == 3) ? 12'h123 : 12'h0A5);
      if (k == 2) d0 = 12'h123;
    end
    enable0 = 1'b0;
    repeat (30) @(negedge clk);
    chk("avg0_one_per_conv", valid0_cnt, conv0_cnt);

`ifdef ADC_SAMPLER_OVERRUN_EN
    chk("ov_main_reset", ovc_main, 0);
    enable_ov = 1'b1;
    n = 0;
    while (!ov_convst && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ov_convst_seen", ov_convst, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("ov_cnt_two", ov_cnt, 2);
    repeat (300 * 16) @(posedge clk);
    #1;
    chk("ov_cnt_saturated", ov_cnt, 255);
    enable_ov = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sampler.md
Name: adc_sampler

Overview:
- Upstream acquisition stage for the solar-panel voltage path.
- Drives the parallel 12-bit ADC through its conversion handshake at a fixed rate, averages 2^AVG_LOG2 conversions, and emits one 12-bit sample with a single-cycle valid strobe.
- Its output feeds the previous-value register and the max comparator, replacing the raw unsynchronised GPIO bus.

Parameters:
- DATA_W, 12: ADC data width and sample output width.
- CLK_DIV, 50000: clk cycles between conversion starts; legal range is 16 or more.
- AVG_LOG2, 2: log2 of the number of conversions averaged per output sample; legal range 0..4.
- CONV_TIMEOUT, 255: maximum clk cycles spent waiting in each busy phase before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new conversions; synchronous.
- adc_busy  in  1  ADC busy flag; asynchronous to clk.
- adc_data  in  DATA_W  ADC parallel data bus; asynchronous to clk.
- adc_convst  out  1  conversion-start pulse to the ADC.
- sample  out  DATA_W  averaged sample.
- sample_valid  out  1  one-cycle strobe; sample is valid while it is high.
- timeout_err  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - Divider, accumulator, capture count and timeout counter all 0.
  - adc_convst=0, sample=0, sample_valid=0, timeout_err=0.
  - Synchroniser flops cleared.
  - Reset mid-operation aborts immediately; no sample_valid follows.
- Synchronisation: adc_busy and adc_data each pass through 2-flop synchronisers clocked by clk. The FSM uses only the synchronised copies (busy_s, data_s).
- Divider:
  - While enable=1, counts 0..CLK_DIV-1 and wraps; tick=1 when count==CLK_DIV-1.
  - While enable=0, held at 0.
  - Ticks arriving while state!=IDLE are dropped.
- FSM:
  - IDLE: on tick, go to CONVST. If enable=0 here, clear the accumulator and capture count.
  - CONVST: adc_convst=1 for exactly 2 cycles, then go to WAIT_HI. adc_convst is registered and is 0 in every other state.
  - WAIT_HI: wait for busy_s=1, then go to WAIT_LO.
  - WAIT_LO: wait for busy_s=0, then go to CAPTURE.
  - CAPTURE (1 cycle):
    - acc <= acc + data_s, where acc is DATA_W+AVG_LOG2 bits and cannot overflow.
    - cnt <= cnt+1.
    - If cnt == 2^AVG_LOG2-1, go to EMIT; otherwise go to IDLE.
  - EMIT (1 cycle):
    - sample <= acc[DATA_W+AVG_LOG2-1:AVG_LOG2] (truncating divide).
    - sample_valid=1 for exactly this cycle.
    - acc and cnt cleared; go to IDLE.
  - sample holds its value between strobes.
- Timeout:
  - The timeout counter clears on entry to WAIT_HI and again on entry to WAIT_LO.
  - If the counter reaches CONV_TIMEOUT in either wait state: timeout_err<=1 (sticky until reset), acc and cnt cleared (partial average discarded), go to IDLE.
  - No sample_valid is produced for the aborted group.
- enable deasserted mid-conversion: the in-flight conversion completes, including EMIT if due. No new CONVST is issued.
- Latency:
  - busy_s falls in cycle k → CAPTURE at k+1 → EMIT (sample_valid high) at k+2.
  - Pin-to-busy_s delay is 2 clk edges.
- Spacing: consecutive adc_convst rising edges are exactly CLK_DIV cycles apart whenever each conversion completes within CLK_DIV-2 cycles.
- AVG_LOG2=0: every capture emits data_s unchanged.

Optional Feature:
- Macro: ADC_SAMPLER_OVERRUN_EN.
- Defined:
  - Adds output overrun_cnt, 8 bits, reset to 0.
  - Increments once per tick that arrives while state!=IDLE, saturating at 255.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; dropped ticks are silent.

Test Plan:
- Reset: assert reset mid-WAIT_LO → adc_convst, sample, sample_valid and timeout_err are all 0 immediately; no sample_valid after release until a full new group completes.
- Averaging: CLK_DIV=32, AVG_LOG2=2, ADC model (busy high 5 cycles) returns 100, 200, 300, 401 → exactly one sample_valid, with sample=250; adc_convst rising edges 32 cycles apart.
- Full scale: four conversions of 4095 → sample=4095; acc does not wrap. AVG_LOG2=0 with data 0x0A5 → sample=0x0A5 after every conversion.
- Timeout: busy never rises, CONV_TIMEOUT=20 → timeout_err=1 after 20 cycles in WAIT_HI. Next conversions return 1000 ×4 → sample=1000 (partial group discarded); timeout_err stays 1.
- Enable drop: deassert enable during WAIT_LO of the 4th conversion → EMIT still occurs; no further adc_convst while enable=0; re-enable → first adc_convst exactly CLK_DIV cycles later.
- ADC_SAMPLER_OVERRUN_EN: busy held high for 3×CLK_DIV cycles → overrun_cnt=2 or 3 per tick alignment (checked against the model); saturates at 255 under a stuck busy with large CONV_TIMEOUT.
